serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Sequencer that time-shares a single 1-bit full-adder slice to add or subtract two WIDTH-bit operands, LSB first, one bit per clock. It has valid/ready handshakes on both sides and reports sum, carry, signed overflow and zero flags. It is the area-minimal alternative to the parallel adders in the ALU datapath and is used by multi-cycle units that can tolerate WIDTH-cycle latency.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  request valid; operands qualified by this
o_ready  output  1  block can accept a request (high only in IDLE)
i_data_a  input  WIDTH  operand A
i_data_b  input  WIDTH  operand B
i_sub  input  1  0 = A+B, 1 = A-B
o_valid  output  1  result valid (high only in DONE)
i_ready  input  1  consumer accepts result
o_data  output  WIDTH  result
o_carry  output  1  carry-out of MSB (for subtract: 1 = no borrow)
o_overflow  output  1  signed two's-complement overflow
o_zero  output  1  o_data == 0
o_busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, i_rst_n low): state=IDLE; o_ready=1; o_valid=0; o_busy=0; o_data=0; o_carry=0; o_overflow=0; o_zero=0; bit counter=0; internal operand and carry registers cleared.
- FSM states: IDLE, RUN, DONE. o_ready=(state==IDLE); o_valid=(state==DONE); o_busy=(state!=IDLE).
- IDLE: on i_valid&&o_ready at an edge, capture the following and go to RUN:
  - A into the A shift register.
  - B^{WIDTH{i_sub}} into the B shift register.
  - Carry flop = i_sub.
  - Counter = 0.
- RUN, each edge:
  - s = a0^b0^c.
  - c_next = majority(a0,b0,c).
  - Shift s into the result register at the MSB, shifting right.
  - Shift the A and B registers right by 1.
  - Counter++.
  - When counter==WIDTH-2 on the edge, latch c (carry into MSB) as c_msb.
  - When counter==WIDTH-1 on the edge, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- Entering DONE: o_data=result; o_carry=final carry; o_overflow=c_msb^final carry; o_zero=(result==0). All are registered and update only on that edge.
- Latency: accept at edge 0; o_valid rises after edge WIDTH.
- DONE: o_valid held and outputs stable while i_ready=0, with no limit on how long. On i_valid... no: on i_ready=1 at an edge, go to IDLE, and o_ready is high the following cycle. A new request is not accepted in the same cycle as the result handoff.
- Result outputs (o_data and flags) retain their last values in IDLE and RUN until the next DONE entry.
- i_valid, i_data_a/b and i_sub are ignored outside IDLE. Operands are sampled only at the accept edge and may change afterwards.
- i_ready is ignored outside DONE.
- Reset asserted mid-RUN or in DONE aborts the operation immediately: all outputs return to their reset values and no o_valid is produced.
- Arithmetic is modulo 2^WIDTH. o_carry for subtract is the inverted borrow.

Test Plan:
- WIDTH=8, A=0x0F, B=0x01, sub=0 -> o_valid exactly 8 cycles after accept; o_data=0x10, carry=0, ov=0, zero=0; o_ready low from accept until after handoff.
- WIDTH=8, A=0xFF, B=0x01, sub=0 -> o_data=0x00, carry=1, ov=0, zero=1. Then A=0x7F, B=0x01 -> o_data=0x80, carry=0, ov=1.
- WIDTH=8, sub=1: A=0x05, B=0x07 -> o_data=0xFE, carry=0, ov=0. A=0x80, B=0x01 -> o_data=0x7F, carry=1, ov=1. A=0x33, B=0x33 -> o_data=0x00, carry=1, zero=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and outputs stable throughout. Toggle i_valid and operands during RUN/DONE -> no effect on the result, no second accept. i_ready=1 -> IDLE; o_ready high next cycle.
- Reset mid-RUN (cycle 3 of 8) -> outputs go to zero immediately and state=IDLE. A post-reset request 0x12+0x34 -> o_data=0x46 after 8 cycles.
- Back-to-back: 100 random A/B/sub with random i_valid/i_ready gaps, WIDTH=8 and WIDTH=32 -> every result and flag matches the reference model; exactly one o_valid handoff per accept.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract sequencer.
// One 1-bit full-adder slice is reused for WIDTH cycles, LSB first, to
// produce the sum/difference of two WIDTH-bit operands plus carry,
// signed-overflow and zero flags.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The input side is ready only in IDLE; the output side
// is valid only in DONE and holds data/flags stable until i_ready.
// Neither valid depends combinationally on the opposite ready.
module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_busy,
    output logic [1:0]       o_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value on the last RUN edge, and on the edge that computes
    // the carry into the MSB.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c;
    logic             c_msb;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    // Full-adder slice on the current LSBs and the result shifted with the new bit
    always_comb begin
        s        = a_sr[0] ^ b_sr[0] ^ c;
        c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
        res_next = {s, res_sr[WIDTH-1:1]};
    end

    // Sequencer: accept in IDLE, one bit per edge in RUN, hold result in DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            c          <= 1'b0;
            c_msb      <= 1'b0;
            cnt        <= '0;
            o_data     <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_zero     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        // Subtraction is A + ~B + 1: invert B and seed carry with 1.
                        a_sr  <= i_data_a;
                        b_sr  <= i_data_b ^ {WIDTH{i_sub}};
                        c     <= i_sub;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sr <= res_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    c      <= c_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_PREV) begin
                        c_msb <= c_next;
                    end
                    if (cnt == CNT_LAST) begin
                        o_data     <= res_next;
                        o_carry    <= c_next;
                        o_overflow <= c_msb ^ c_next;
                        o_zero     <= (res_next == '0);
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status decode straight from the state register
    always_comb begin
        o_ready = (state == ST_IDLE);
        o_valid = (state == ST_DONE);
        o_busy  = (state != ST_IDLE);
        o_state = state;
    end

endmodule
